// File: rtl/ad_bus_pkg.sv
// ad_bus_pkg: shared state type and counter-width helper for the AD bus arbiter
package ad_bus_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, TURN} ad_arb_state_t;
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/ad_rr_pick.sv
// ad_rr_pick: round-robin pick of the first request at or above the pointer, with wrap
module ad_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            any
);
    localparam int DW = 2 * NREQ;
    logic [DW-1:0] masked;
    // Upper copy keeps every request eligible, so the wrap falls out of a plain priority scan
    always_comb begin
        masked = {req, req} & ~((DW'(1) << ptr) - DW'(1));
        idx = '0;
        for (int i = DW - 1; i >= 0; i--) begin
            if (masked[i]) idx = IW'(i % NREQ);
        end
    end
    assign any = |req;
    assign onehot = any ? (NREQ'(1) << idx) : '0;
endmodule

// File: rtl/ad_bus_arbiter.sv
// ad_bus_arbiter: round-robin owner sequencing of the shared AD bus with bounded tenures
// and registered, turnaround-separated bufif0 enables.
module ad_bus_arbiter
    import ad_bus_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int MAX_BURST = 8,
    parameter int TURNAROUND = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         drv_n,
    output logic                    bus_busy,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    preempt
);
    localparam int IW = $clog2(NREQ);
    localparam int BW = cnt_w(MAX_BURST);
    localparam int TW = cnt_w(TURNAROUND);
    localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURNAROUND - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

    if (TURNAROUND < 1 || TURNAROUND > 3 || NREQ < 2 || NREQ > 8 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_param
        $error("ad_bus_arbiter: parameter out of range");
    end

    ad_arb_state_t state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d, pick_oh;
    logic [IW-1:0] owner_q, owner_d, ptr_q, ptr_d, pick_idx;
    logic [BW-1:0] beat_q, beat_d;
    logic [TW-1:0] turn_q, turn_d;
    logic preempt_q, preempt_d, pick_any, start, drop;

    ad_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // A request drop wins over the burst limit, so preempt only marks pure limit releases
    always_comb begin
        drop = !req[owner_q];
        start = pick_any && (state_q == IDLE || (state_q == TURN && turn_q == TURN_LAST));
        state_d = state_q;
        gnt_d = gnt_q;
        owner_d = owner_q;
        ptr_d = ptr_q;
        beat_d = (state_q == GRANT) ? beat_q + 1'b1 : beat_q;
        turn_d = (state_q == TURN) ? turn_q + 1'b1 : turn_q;
        preempt_d = 1'b0;
        if (start) begin
            state_d = GRANT;
            gnt_d = pick_oh;
            owner_d = pick_idx;
            ptr_d = (pick_idx == IDX_LAST) ? '0 : pick_idx + 1'b1;
            beat_d = '0;
        end else if (state_q == TURN && turn_q == TURN_LAST) begin
            state_d = IDLE;
        end else if (state_q == GRANT && (drop || beat_d == BEAT_LAST)) begin
            state_d = TURN;
            gnt_d = '0;
            turn_d = '0;
            preempt_d = !drop;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q <= '0;
            owner_q <= '0;
            ptr_q <= '0;
            beat_q <= '0;
            turn_q <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q <= gnt_d;
            owner_q <= owner_d;
            ptr_q <= ptr_d;
            beat_q <= beat_d;
            turn_q <= turn_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt = gnt_q;
    assign drv_n = ~gnt_q;
    assign bus_busy = (state_q != IDLE);
    assign owner = owner_q;
    assign preempt = preempt_q;

    a_onehot: assert property (@(posedge clk) $onehot0(gnt));
    a_drv: assert property (@(posedge clk) drv_n == ~gnt);
    a_req_known: assert property (@(posedge clk) disable iff (reset) !$isunknown(req));
    a_no_handover: assert property (@(posedge clk) disable iff (reset) (|gnt) && (|$past(gnt)) |-> gnt == $past(gnt));
    for (genvar k = 1; k <= TURNAROUND; k++) begin : g_gap
        a_gap: assert property (@(posedge clk) disable iff (reset) $rose(|gnt) |-> $past(gnt, k) == '0);
    end
endmodule

// File: tb/tb_ad_bus_arbiter.sv
// tb_ad_bus_arbiter: directed scoreboard bench for the AD bus arbiter (TURNAROUND 1 and 3 instances)
module tb_ad_bus_arbiter;
    typedef struct packed {
        logic [3:0] gnt;
        logic       busy;
        logic [1:0] owner;
        logic       pre;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] req_a = 4'b0, req_b = 4'b0;
    logic [3:0] gnt_a, drv_n_a, gnt_b, drv_n_b;
    logic busy_a, busy_b, pre_a, pre_b;
    logic [1:0] owner_a, owner_b;
    exp_t qa[$];
    exp_t qb[$];
    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    ad_bus_arbiter #(.NREQ(4), .MAX_BURST(8), .TURNAROUND(1)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .gnt(gnt_a), .drv_n(drv_n_a),
        .bus_busy(busy_a), .owner(owner_a), .preempt(pre_a)
    );

    ad_bus_arbiter #(.NREQ(4), .MAX_BURST(8), .TURNAROUND(3)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .gnt(gnt_b), .drv_n(drv_n_b),
        .bus_busy(busy_b), .owner(owner_b), .preempt(pre_b)
    );

    function automatic exp_t mk(input logic [3:0] g, input logic b, input logic [1:0] o, input logic p);
        exp_t e;
        e.gnt = g;
        e.busy = b;
        e.owner = o;
        e.pre = p;
        return e;
    endfunction

    task automatic step_a(input logic rst, input logic [3:0] r, input exp_t e);
        @(negedge clk);
        reset = rst;
        req_a = r;
        qa.push_back(e);
    endtask

    task automatic step_b(input logic rst, input logic [3:0] r, input exp_t e);
        @(negedge clk);
        reset = rst;
        req_b = r;
        qb.push_back(e);
    endtask

    task automatic check(input string name, input exp_t e, input logic [3:0] g, input logic [3:0] dn,
                         input logic b, input logic [1:0] o, input logic p);
        tests++;
        if (g !== e.gnt || dn !== ~e.gnt || b !== e.busy || o !== e.owner || p !== e.pre) begin
            failed++;
            $display("FAIL %s @%0t: got gnt=%b drv_n=%b busy=%b owner=%0d preempt=%b, want gnt=%b drv_n=%b busy=%b owner=%0d preempt=%b",
                     name, $time, g, dn, b, o, p, e.gnt, ~e.gnt, e.busy, e.owner, e.pre);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (qa.size() > 0) check("dut_a", qa.pop_front(), gnt_a, drv_n_a, busy_a, owner_a, pre_a);
        if (qb.size() > 0) check("dut_b", qb.pop_front(), gnt_b, drv_n_b, busy_b, owner_b, pre_b);
    end

    initial begin
        for (int i = 0; i < 3; i++) step_a(1'b1, 4'b0000, mk(4'b0000, 1'b0, 2'd0, 1'b0));
        for (int i = 0; i < 10; i++) step_a(1'b0, 4'b0000, mk(4'b0000, 1'b0, 2'd0, 1'b0));
        // All requesting: four full preempted tenures, then owner 0 again
        for (int t = 0; t < 4; t++) begin
            for (int b = 0; b < 8; b++) step_a(1'b0, 4'b1111, mk(4'b0001 << t, 1'b1, 2'(t), 1'b0));
            step_a(1'b0, 4'b1111, mk(4'b0000, 1'b1, 2'(t), 1'b1));
        end
        for (int b = 0; b < 8; b++) step_a(1'b0, 4'b1111, mk(4'b0001, 1'b1, 2'd0, 1'b0));
        // Drop coincides with the burst limit: no preempt
        step_a(1'b0, 4'b0000, mk(4'b0000, 1'b1, 2'd0, 1'b0));
        step_a(1'b0, 4'b0000, mk(4'b0000, 1'b0, 2'd0, 1'b0));
        for (int i = 0; i < 3; i++) step_a(1'b0, 4'b0100, mk(4'b0100, 1'b1, 2'd2, 1'b0));
        step_a(1'b0, 4'b0000, mk(4'b0000, 1'b1, 2'd2, 1'b0));
        step_a(1'b0, 4'b0000, mk(4'b0000, 1'b0, 2'd2, 1'b0));
        // Pointer 3 -> grant 1, leaving the pointer at 2
        step_a(1'b0, 4'b0010, mk(4'b0010, 1'b1, 2'd1, 1'b0));
        step_a(1'b0, 4'b0000, mk(4'b0000, 1'b1, 2'd1, 1'b0));
        step_a(1'b0, 4'b0000, mk(4'b0000, 1'b0, 2'd1, 1'b0));
        step_a(1'b0, 4'b1010, mk(4'b1000, 1'b1, 2'd3, 1'b0));
        step_a(1'b0, 4'b0010, mk(4'b0000, 1'b1, 2'd3, 1'b0));
        step_a(1'b0, 4'b0010, mk(4'b0010, 1'b1, 2'd1, 1'b0));
        step_a(1'b0, 4'b0000, mk(4'b0000, 1'b1, 2'd1, 1'b0));
        step_a(1'b0, 4'b0000, mk(4'b0000, 1'b0, 2'd1, 1'b0));
        // Asynchronous reset in the middle of a tenure
        step_a(1'b0, 4'b1111, mk(4'b0100, 1'b1, 2'd2, 1'b0));
        step_a(1'b0, 4'b1111, mk(4'b0100, 1'b1, 2'd2, 1'b0));
        step_a(1'b1, 4'b1111, mk(4'b0000, 1'b0, 2'd0, 1'b0));
        #1;
        tests++;
        if (drv_n_a !== 4'b1111 || gnt_a !== 4'b0000 || busy_a !== 1'b0) begin
            failed++;
            $display("FAIL async_reset: got drv_n=%b gnt=%b busy=%b, want drv_n=1111 gnt=0000 busy=0", drv_n_a, gnt_a, busy_a);
        end
        step_a(1'b1, 4'b1111, mk(4'b0000, 1'b0, 2'd0, 1'b0));
        step_a(1'b0, 4'b1111, mk(4'b0001, 1'b1, 2'd0, 1'b0));
        step_a(1'b0, 4'b0000, mk(4'b0000, 1'b1, 2'd0, 1'b0));
        step_a(1'b0, 4'b0000, mk(4'b0000, 1'b0, 2'd0, 1'b0));
        // Lone requester preempted, then re-granted after the turnaround
        for (int b = 0; b < 8; b++) step_a(1'b0, 4'b0001, mk(4'b0001, 1'b1, 2'd0, 1'b0));
        step_a(1'b0, 4'b0001, mk(4'b0000, 1'b1, 2'd0, 1'b1));
        step_a(1'b0, 4'b0001, mk(4'b0001, 1'b1, 2'd0, 1'b0));
        step_a(1'b0, 4'b0000, mk(4'b0000, 1'b1, 2'd0, 1'b0));
        step_a(1'b0, 4'b0000, mk(4'b0000, 1'b0, 2'd0, 1'b0));
        // TURNAROUND=3: handover from 0 to 1 leaves exactly three idle cycles
        step_b(1'b0, 4'b0001, mk(4'b0001, 1'b1, 2'd0, 1'b0));
        for (int i = 0; i < 3; i++) step_b(1'b0, 4'b0010, mk(4'b0000, 1'b1, 2'd0, 1'b0));
        step_b(1'b0, 4'b0010, mk(4'b0010, 1'b1, 2'd1, 1'b0));
        for (int i = 0; i < 3; i++) step_b(1'b0, 4'b0000, mk(4'b0000, 1'b1, 2'd1, 1'b0));
        step_b(1'b0, 4'b0000, mk(4'b0000, 1'b0, 2'd1, 1'b0));
        repeat (2) @(posedge clk);
        #2;
        tests++;
        if (qa.size() + qb.size() != 0) begin
            failed++;
            $display("FAIL drain: got %0d unchecked expectations, want 0", qa.size() + qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/ad_bus_arbiter.md
Name: ad_bus_arbiter

Overview:
Sequences ownership of the shared 32-bit tri-state AD bus. Each requester's AD driver is a bufif0 bank with an active-low enable. The block arbitrates round-robin among NREQ requesters and bounds each tenure to MAX_BURST beats. It inserts TURNAROUND idle cycles between owners so that two driver banks are never enabled together. It sits beside the bus drivers and produces their enables directly from registers.

Parameters:
NREQ, 4, number of requesters (2..8)
MAX_BURST, 8, maximum consecutive granted cycles per tenure (1..255)
TURNAROUND, 1, idle cycles with no driver between tenures (1..3; 0 illegal, elaboration error)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high
req  input  NREQ  per-requester bus request, level, held until done
gnt  output  NREQ  one-hot grant, registered
drv_n  output  NREQ  active-low bufif0 enable per requester; always equals ~gnt
bus_busy  output  1  high while any gnt bit is set or while in turnaround
owner  output  $clog2(NREQ)  index of current or most recent owner
preempt  output  1  one-cycle pulse when a tenure ends by MAX_BURST rather than by req drop

Behaviour:
- Reset, asynchronous, all outputs and state:
  - gnt=0, drv_n=all ones, bus_busy=0, owner=0, preempt=0
  - state=IDLE, rr pointer=0, so requester 0 has highest priority first
  - beat counter=0, turnaround counter=0
- States:
  - IDLE: no grant. If any req is high at a clock edge, go to GRANT at that edge, with gnt set to the rr pick.
  - GRANT: exactly one gnt bit set; beat counter increments every cycle.
  - TURN: gnt=0, bus_busy=1; turnaround counter runs for TURNAROUND cycles.
- Latency: req sampled high in IDLE gives gnt high on the next edge (1 cycle). No combinational path from req to gnt or drv_n.
- rr pick:
  - Scans from pointer upward with wrap at NREQ-1 and takes the first set req.
  - On each grant the pointer becomes (winner+1) mod NREQ.
  - owner updates to the winner.
- GRANT exit, evaluated each edge using the current cycle's req and count:
  - req[owner]==0: release. Go to TURN at this edge; the granted-but-unused cycle counts as a beat.
  - Beat counter reaches MAX_BURST: forced release. Go to TURN; preempt pulses high for the first TURN cycle.
  - Both conditions in the same cycle: treat as a req drop; preempt stays 0.
- Tenure length: the owner holds gnt for at most MAX_BURST consecutive cycles. The beat counter resets to 0 on entry to GRANT and is $clog2(MAX_BURST+1) bits wide.
- TURN exit: after TURNAROUND cycles:
  - any req high: go to GRANT with a new pick, with no IDLE cycle in between;
  - otherwise: go to IDLE.
  - A requester preempted while still requesting competes normally. With a single active requester it is re-granted after TURNAROUND.
- Requests that drop while the requester is not granted are simply not picked; no latching.
- bus_busy = (state != IDLE).
- Invariants, checked by assertions:
  - $onehot0(gnt) at every cycle.
  - drv_n == ~gnt at every cycle.
  - At every owner change, at least TURNAROUND cycles with gnt==0 separate the two tenures.
- Reset mid-tenure: drv_n goes to all ones asynchronously, immediately releasing the bus; state returns to IDLE.
- Unknown (X) on req: assertion failure in simulation; no X-tolerance logic in RTL.

Decomposition:
- Package ad_bus_pkg holds:
  - typedef enum logic [1:0] {IDLE, GRANT, TURN} ad_arb_state_t
  - localparam helpers for counter widths
- Sub-module ad_rr_pick: combinational round-robin picker.
  - Inputs: req vector and pointer.
  - Outputs: one-hot winner, winner index, any-valid flag.
  - Implemented as a double-width masked priority encode.
- All registers, counters and the FSM live in ad_bus_arbiter.

Test Plan:
- Reset release with req=4'b0000 for 10 cycles -> gnt=0, drv_n=4'b1111, bus_busy=0 throughout.
- req=4'b1111 held, MAX_BURST=8, TURNAROUND=1 -> tenures granted to 0,1,2,3,0:
  - each tenure lasts 8 cycles with preempt pulsing after it;
  - exactly 1 cycle with gnt=0 between tenures.
- req[2] asserted alone for 3 cycles then dropped -> gnt=4'b0100 from cycle 1 to cycle 3, then TURN, then IDLE; owner=2, preempt never asserted.
- req[1] and req[3] set in the same cycle, pointer=2 -> gnt[3] first; after it releases, gnt[1].
- Reset asserted asynchronously mid-GRANT, between clock edges -> drv_n=4'b1111 in the same timestep; after release, first grant goes to requester 0 when req=4'b1111.
- TURNAROUND=3, req[0] dropped and req[1] raised in the same cycle -> gnt is 0 for exactly 3 cycles, then gnt=4'b0010; the onehot0 assertion never fires.
